// File: rtl/fgpio_sched.sv
// Fast-GPIO front end: core pass-through with fixed priority, plus a sequencer
// that replays queued ops from a FIFO after a per-command cycle delay.
module fgpio_sched #(
  parameter int DEPTH = 8,
  parameter int DLY_W = 16
) (
  input  logic                       clk_neg_i,
  input  logic                       rst_ni,
  input  logic                       core_req,
  input  logic [6:0]                 core_funct7,
  input  logic [31:0]                core_rs1_val,
  input  logic [31:0]                core_rs2_val,
  output logic                       core_ack,
  output logic                       core_error,
  output logic [31:0]                core_rd_val,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [6:0]                 cmd_funct7,
  input  logic [31:0]                cmd_rs1_val,
  input  logic [31:0]                cmd_rs2_val,
  input  logic [DLY_W-1:0]           cmd_delay,
  input  logic                       seq_en,
  input  logic                       seq_flush,
  output logic                       seq_busy,
  output logic [$clog2(DEPTH):0]     fifo_cnt,
  output logic                       res_valid,
  output logic [31:0]                res_rd_val,
  output logic                       res_error,
  output logic                       fgpio_req,
  output logic [6:0]                 fgpio_funct7,
  output logic [31:0]                fgpio_rs1_val,
  output logic [31:0]                fgpio_rs2_val,
  input  logic                       fgpio_ack,
  input  logic                       fgpio_error,
  input  logic [31:0]                fgpio_rd_val
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

  state_t state, state_nxt;

  logic [6:0]       mem_funct7 [DEPTH];
  logic [31:0]      mem_rs1    [DEPTH];
  logic [31:0]      mem_rs2    [DEPTH];
  logic [DLY_W-1:0] mem_dly    [DEPTH];

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop;

  logic [6:0]       stg_funct7;
  logic [31:0]      stg_rs1, stg_rs2;
  logic [DLY_W-1:0] dly_cnt;
  logic             seq_drive, done;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full && !seq_flush;
  assign push      = cmd_valid && cmd_ready;
  assign done      = seq_drive && fgpio_ack;
  assign seq_busy  = !empty || (state != IDLE);
  assign fifo_cnt  = count;

  always_ff @(posedge clk_neg_i) begin
    if (push) begin
      mem_funct7[wr_ptr] <= cmd_funct7;
      mem_rs1[wr_ptr]    <= cmd_rs1_val;
      mem_rs2[wr_ptr]    <= cmd_rs2_val;
      mem_dly[wr_ptr]    <= cmd_delay;
    end
  end

  always_ff @(posedge clk_neg_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (seq_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_neg_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Flush overrides everything; a collided issue just stays in ISSUE and retries.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    seq_drive = 1'b0;
    if (seq_flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (seq_en && !empty) begin
            pop       = 1'b1;
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (dly_cnt == '0) state_nxt = ISSUE;
        end
        ISSUE: begin
          if (seq_en && !core_req) begin
            seq_drive = 1'b1;
            if (fgpio_ack) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_neg_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_funct7 <= '0;
      stg_rs1    <= '0;
      stg_rs2    <= '0;
      dly_cnt    <= '0;
      res_valid  <= 1'b0;
      res_rd_val <= '0;
      res_error  <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (seq_flush) begin
        dly_cnt <= '0;
      end else if (pop) begin
        stg_funct7 <= mem_funct7[rd_ptr];
        stg_rs1    <= mem_rs1[rd_ptr];
        stg_rs2    <= mem_rs2[rd_ptr];
        dly_cnt    <= mem_dly[rd_ptr];
      end else if (state == WAIT && dly_cnt != '0 && seq_en) begin
        dly_cnt <= dly_cnt - DLY_W'(1);
      end
      if (done) begin
        res_valid  <= 1'b1;
        res_rd_val <= fgpio_rd_val;
        res_error  <= fgpio_error;
      end
    end
  end

  // Core always wins the port; the sequencer only sees it when the core is quiet.
  always_comb begin
    fgpio_req     = 1'b0;
    fgpio_funct7  = '0;
    fgpio_rs1_val = '0;
    fgpio_rs2_val = '0;
    core_ack      = 1'b0;
    core_error    = 1'b0;
    core_rd_val   = '0;
    if (core_req) begin
      fgpio_req     = 1'b1;
      fgpio_funct7  = core_funct7;
      fgpio_rs1_val = core_rs1_val;
      fgpio_rs2_val = core_rs2_val;
      core_ack      = fgpio_ack;
      core_error    = fgpio_error;
      core_rd_val   = fgpio_rd_val;
    end else if (seq_drive) begin
      fgpio_req     = 1'b1;
      fgpio_funct7  = stg_funct7;
      fgpio_rs1_val = stg_rs1;
      fgpio_rs2_val = stg_rs2;
    end
  end

endmodule

// File: tb/tb_fgpio_sched.sv
// Directed bench for fgpio_sched: arbiter vector table plus timed sequencer scenarios
// against a simple GPIO unit model (rd = rs1+rs2, funct7 0x2A is illegal).
module tb_fgpio_sched;

  localparam int DEPTH = 8;
  localparam int DLY_W = 16;

  logic              clk_neg_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              core_req = 1'b0;
  logic [6:0]        core_funct7 = '0;
  logic [31:0]       core_rs1_val = '0, core_rs2_val = '0;
  logic              core_ack, core_error;
  logic [31:0]       core_rd_val;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [6:0]        cmd_funct7 = '0;
  logic [31:0]       cmd_rs1_val = '0, cmd_rs2_val = '0;
  logic [DLY_W-1:0]  cmd_delay = '0;
  logic              seq_en = 1'b0, seq_flush = 1'b0;
  logic              seq_busy;
  logic [3:0]        fifo_cnt;
  logic              res_valid, res_error;
  logic [31:0]       res_rd_val;
  logic              fgpio_req;
  logic [6:0]        fgpio_funct7;
  logic [31:0]       fgpio_rs1_val, fgpio_rs2_val;
  logic              fgpio_ack, fgpio_error;
  logic [31:0]       fgpio_rd_val;
  logic              gpio_stall = 1'b0;

  int total = 0;
  int bad = 0;

  assign fgpio_error  = fgpio_req && (fgpio_funct7 == 7'b0101010);
  assign fgpio_ack    = fgpio_req && !gpio_stall;
  assign fgpio_rd_val = (fgpio_req && !fgpio_error) ? fgpio_rs1_val + fgpio_rs2_val : 32'd0;

  fgpio_sched #(.DEPTH(DEPTH), .DLY_W(DLY_W)) dut (
    .clk_neg_i(clk_neg_i), .rst_ni(rst_ni),
    .core_req(core_req), .core_funct7(core_funct7),
    .core_rs1_val(core_rs1_val), .core_rs2_val(core_rs2_val),
    .core_ack(core_ack), .core_error(core_error), .core_rd_val(core_rd_val),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct7(cmd_funct7),
    .cmd_rs1_val(cmd_rs1_val), .cmd_rs2_val(cmd_rs2_val), .cmd_delay(cmd_delay),
    .seq_en(seq_en), .seq_flush(seq_flush), .seq_busy(seq_busy), .fifo_cnt(fifo_cnt),
    .res_valid(res_valid), .res_rd_val(res_rd_val), .res_error(res_error),
    .fgpio_req(fgpio_req), .fgpio_funct7(fgpio_funct7),
    .fgpio_rs1_val(fgpio_rs1_val), .fgpio_rs2_val(fgpio_rs2_val),
    .fgpio_ack(fgpio_ack), .fgpio_error(fgpio_error), .fgpio_rd_val(fgpio_rd_val)
  );

  always #5 clk_neg_i = ~clk_neg_i;

  typedef struct {
    logic        core_req;
    logic [6:0]  f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        stall;
    logic        exp_req;
    logic [6:0]  exp_f7;
    logic [31:0] exp_rs1;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    core_req     = v.core_req;
    core_funct7  = v.f7;
    core_rs1_val = v.rs1;
    core_rs2_val = v.rs2;
    gpio_stall   = v.stall;
  endtask

  task automatic tick();
    @(posedge clk_neg_i);
    #1;
  endtask

  task automatic push_cmd(input logic [6:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [DLY_W-1:0] d);
    cmd_valid   = 1'b1;
    cmd_funct7  = f;
    cmd_rs1_val = a;
    cmd_rs2_val = b;
    cmd_delay   = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] req_mask, res_mask;
    logic [31:0] issued[$];
    logic [31:0] got[$];
    logic [31:0] exp_rs1s[3];
    int          hits;
    logic        found;

    vecs[0] = '{1'b1, 7'h01, 32'd5,          32'd7, 1'b0, 1'b1, 7'h01, 32'd5,          1'b1, 1'b0, 32'd12};
    vecs[1] = '{1'b1, 7'h2A, 32'd100,        32'd3, 1'b0, 1'b1, 7'h2A, 32'd100,        1'b1, 1'b1, 32'd0};
    vecs[2] = '{1'b1, 7'h10, 32'hFFFF_FFFF,  32'd1, 1'b0, 1'b1, 7'h10, 32'hFFFF_FFFF,  1'b1, 1'b0, 32'd0};
    vecs[3] = '{1'b1, 7'h03, 32'd10,         32'd20, 1'b1, 1'b1, 7'h03, 32'd10,        1'b0, 1'b0, 32'd30};
    vecs[4] = '{1'b0, 7'h05, 32'd9,          32'd9, 1'b0, 1'b0, 7'h00, 32'd0,          1'b0, 1'b0, 32'd0};

    // Reset state
    #3;
    checkOutput("rst_fifo_cnt", fifo_cnt, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_seq_busy", seq_busy, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_fgpio_req", fgpio_req, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    // Arbiter pass-through vectors with the sequencer idle
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk_neg_i);
      checkOutput($sformatf("vec%0d_fgpio_req", i), fgpio_req, vecs[i].exp_req);
      checkOutput($sformatf("vec%0d_fgpio_funct7", i), fgpio_funct7, vecs[i].exp_f7);
      checkOutput($sformatf("vec%0d_fgpio_rs1", i), fgpio_rs1_val, vecs[i].exp_rs1);
      checkOutput($sformatf("vec%0d_core_ack", i), core_ack, vecs[i].exp_ack);
      checkOutput($sformatf("vec%0d_core_error", i), core_error, vecs[i].exp_err);
      checkOutput($sformatf("vec%0d_core_rd", i), core_rd_val, vecs[i].exp_rd);
      tick();
    end
    core_req   = 1'b0;
    gpio_stall = 1'b0;

    $display("[TB] three commands, delays 0/2/5");
    push_cmd(7'h01, 32'd10, 32'd1, 16'd0);
    push_cmd(7'h02, 32'd20, 32'd2, 16'd2);
    push_cmd(7'h03, 32'd30, 32'd3, 16'd5);
    checkOutput("seq1_fifo_cnt_3", fifo_cnt, 3);
    seq_en = 1'b1;
    req_mask = '0;
    res_mask = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_neg_i);
      if (fgpio_req) begin
        req_mask[k] = 1'b1;
        issued.push_back(fgpio_rs1_val);
      end
      if (res_valid) res_mask[k] = 1'b1;
      tick();
    end
    checkOutput("seq1_req_cycles", req_mask, 32'h0000_8084);
    checkOutput("seq1_res_cycles", res_mask, 32'h0001_0108);
    checkOutput("seq1_issue_count", issued.size(), 3);
    exp_rs1s = '{32'd10, 32'd20, 32'd30};
    for (int i = 0; i < issued.size() && i < 3; i++)
      checkOutput($sformatf("seq1_issue%0d_rs1", i), issued[i], exp_rs1s[i]);
    checkOutput("seq1_fifo_cnt_0", fifo_cnt, 0);
    checkOutput("seq1_last_rd", res_rd_val, 33);

    $display("[TB] fill FIFO, overflow push, drain with wrap");
    seq_en = 1'b0;
    for (int i = 0; i < 8; i++) push_cmd(7'h04, 32'd100 + i, i, 16'd0);
    checkOutput("seq2_cmd_ready_full", cmd_ready, 0);
    push_cmd(7'h04, 32'd999, 32'd0, 16'd0);
    checkOutput("seq2_fifo_cnt_8", fifo_cnt, 8);
    seq_en = 1'b1;
    for (int k = 0; k < 60 && got.size() < 8; k++) begin
      @(negedge clk_neg_i);
      if (res_valid) got.push_back(res_rd_val);
      tick();
    end
    checkOutput("seq2_result_count", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++)
      checkOutput($sformatf("seq2_res%0d", i), got[i], 32'd100 + 2 * i);
    tick();
    checkOutput("seq2_fifo_cnt_0", fifo_cnt, 0);
    checkOutput("seq2_seq_busy", seq_busy, 0);

    $display("[TB] core collision during sequencer issue");
    push_cmd(7'h06, 32'h1234, 32'h10, 16'd0);
    for (int k = 0; k < 9; k++) begin
      core_req     = (k >= 2 && k <= 5);
      core_funct7  = 7'h01;
      core_rs1_val = 32'hC0DE_0000 + k;
      core_rs2_val = 32'd1;
      @(negedge clk_neg_i);
      if (k >= 2 && k <= 5) begin
        checkOutput($sformatf("seq3_c%0d_fgpio_rs1", k), fgpio_rs1_val, 32'hC0DE_0000 + k);
        checkOutput($sformatf("seq3_c%0d_core_ack", k), core_ack, 1);
      end
      if (k == 6) begin
        checkOutput("seq3_retry_req", fgpio_req, 1);
        checkOutput("seq3_retry_funct7", fgpio_funct7, 7'h06);
        checkOutput("seq3_retry_rs1", fgpio_rs1_val, 32'h1234);
        checkOutput("seq3_retry_core_ack", core_ack, 0);
      end
      if (k == 7) begin
        checkOutput("seq3_res_valid", res_valid, 1);
        checkOutput("seq3_res_rd", res_rd_val, 32'h1244);
      end
      tick();
    end
    core_req = 1'b0;

    $display("[TB] delay freeze while seq_en low");
    seq_en = 1'b0;
    push_cmd(7'h01, 32'd5, 32'd5, 16'd10);
    req_mask = '0;
    for (int k = 0; k < 25; k++) begin
      seq_en = !(k >= 3 && k <= 7);
      @(negedge clk_neg_i);
      if (fgpio_req) req_mask[k] = 1'b1;
      tick();
    end
    checkOutput("seq4_req_cycles", req_mask, 32'h0002_0000);

    $display("[TB] flush in WAIT");
    seq_en = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(7'h01, 32'd50 + i, 32'd0, 16'd20);
    seq_en = 1'b1;
    tick();
    tick();
    tick();
    seq_flush  = 1'b1;
    cmd_valid  = 1'b1;
    cmd_delay  = 16'd0;
    @(negedge clk_neg_i);
    checkOutput("seq5_cmd_ready_flush", cmd_ready, 0);
    checkOutput("seq5_fifo_cnt_4", fifo_cnt, 4);
    checkOutput("seq5_busy_before", seq_busy, 1);
    tick();
    seq_flush = 1'b0;
    cmd_valid = 1'b0;
    checkOutput("seq5_busy_after", seq_busy, 0);
    checkOutput("seq5_fifo_cnt_0", fifo_cnt, 0);
    hits = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_neg_i);
      if (fgpio_req || res_valid) hits++;
      tick();
    end
    checkOutput("seq5_no_activity", hits, 0);

    $display("[TB] illegal op error and async reset");
    push_cmd(7'b0101010, 32'd77, 32'd1, 16'd0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk_neg_i);
      if (res_valid) found = 1'b1;
      else tick();
    end
    checkOutput("seq6_res_valid", found, 1);
    checkOutput("seq6_res_error", res_error, 1);
    checkOutput("seq6_res_rd", res_rd_val, 0);
    tick();
    checkOutput("seq6_res_valid_pulse", res_valid, 0);
    checkOutput("seq6_res_error_hold", res_error, 1);

    push_cmd(7'h01, 32'd1, 32'd1, 16'd10);
    tick();
    tick();
    tick();
    checkOutput("seq6_busy_in_wait", seq_busy, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("arst_seq_busy", seq_busy, 0);
    checkOutput("arst_fifo_cnt", fifo_cnt, 0);
    checkOutput("arst_res_error", res_error, 0);
    checkOutput("arst_res_rd", res_rd_val, 0);
    checkOutput("arst_res_valid", res_valid, 0);
    checkOutput("arst_fgpio_req", fgpio_req, 0);
    checkOutput("arst_cmd_ready", cmd_ready, 1);
    tick();
    rst_ni = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
